// File: rtl/dma_read_arbiter.sv
// Two-master Avalon-MM burst-read arbiter with an in-order burst ownership tracker.
// Optional round-robin tie-break is enabled by defining ARB_ROUND_ROBIN_EN.
module dma_read_arbiter #(
    parameter int ADDR_W          = 30,
    parameter int DATA_W          = 32,
    parameter int BURST_W         = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk_dma,
    input  logic               reset_dma,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic               m0_read,
    input  logic [BURST_W-1:0] m0_burstcount,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic               m1_read,
    input  logic [BURST_W-1:0] m1_burstcount,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  slv_addr,
    output logic               slv_read,
    output logic [BURST_W-1:0] slv_burstcount,
    input  logic [DATA_W-1:0]  slv_readdata,
    input  logic               slv_readdatavalid,
    input  logic               slv_waitrequest
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_M0,
        ARB_M1
    } arb_state_t;

    arb_state_t state;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               trk_id  [MAX_OUTSTANDING];
    logic [BURST_W-1:0] trk_len [MAX_OUTSTANDING];
    logic [BURST_W-1:0] beat_cnt;

    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               push_id;
    logic               beat;
    logic               pop;
    logic               head_id;
    logic [BURST_W-1:0] head_len;
    logic [BURST_W-1:0] head_last;
    logic               pick_m1;

    assign full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count == '0);

    always_comb begin
        slv_addr       = '0;
        slv_read       = 1'b0;
        slv_burstcount = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state)
            ARB_M0: begin
                slv_addr       = m0_addr;
                slv_read       = m0_read;
                slv_burstcount = m0_burstcount;
                m0_waitrequest = slv_waitrequest;
            end
            ARB_M1: begin
                slv_addr       = m1_addr;
                slv_read       = m1_read;
                slv_burstcount = m1_burstcount;
                m1_waitrequest = slv_waitrequest;
            end
            default: begin
            end
        endcase
    end

    assign accept  = slv_read && !slv_waitrequest;
    assign push    = accept;
    assign push_id = (state == ARB_M1);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the master that did not win the last acceptance goes next.
    assign pick_m1 = m1_read && (!m0_read || !last_grant);

    always_ff @(posedge clk_dma) begin
        if (!reset_dma) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= push_id;
        end
    end
`else
    assign pick_m1 = m1_read && !m0_read;
`endif

    always_ff @(posedge clk_dma) begin
        if (!reset_dma) begin
            state <= ARB_IDLE;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (!full && (m0_read || m1_read)) begin
                        state <= pick_m1 ? ARB_M1 : ARB_M0;
                    end
                end
                // A master dropping read before acceptance abandons the grant.
                ARB_M0: begin
                    if (accept || !m0_read) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_M1: begin
                    if (accept || !m1_read) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign head_id   = trk_id[rd_ptr];
    assign head_len  = trk_len[rd_ptr];
    assign head_last = (head_len == '0) ? '0 : head_len - BURST_W'(1);

    assign beat = slv_readdatavalid && !empty;
    assign pop  = beat && (beat_cnt == head_last);

    assign m0_readdatavalid = beat && !head_id;
    assign m1_readdatavalid = beat && head_id;
    assign m0_readdata      = slv_readdata;
    assign m1_readdata      = slv_readdata;

    always_ff @(posedge clk_dma) begin
        if (push) begin
            trk_id[wr_ptr]  <= push_id;
            trk_len[wr_ptr] <= slv_burstcount;
        end
    end

    always_ff @(posedge clk_dma) begin
        if (!reset_dma) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BURST_W'(1);
            end
        end
    end

endmodule
